sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO, successor to the dual-clock FIFO for paths where producer and consumer share one clock.
Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
Sits between same-clock pipeline stages as an elastic buffer; no synchronisers, no Gray coding.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/sync_fifo_ram.sv | 29 ++
 rtl/sync_fifo_flags.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_flags.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth/count-width arithmetic and parameter range checks,
// common to the single-clock and dual-clock FIFO families.
package fifo_pkg;

  function automatic int fifo_depth(input int asize);
    return 32'sd1 << asize;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int fifo_count_width(input int asize);
    return asize + 32'sd1;
  endfunction

  function automatic bit fifo_params_ok(input int dsize, input int asize,
                                        input int afull_th, input int aempty_th,
                                        input int fwft);
    return (dsize >= 32'sd1) && (asize >= 32'sd1) &&
           (afull_th >= 32'sd1) && (afull_th <= fifo_depth(asize)) &&
           (aempty_th >= 32'sd0) && (aempty_th <= fifo_depth(asize) - 32'sd1) &&
           ((fwft == 32'sd0) || (fwft == 32'sd1));
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DSIZE flop-array storage: one synchronous write port, one asynchronous read port.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int CW = fifo_count_width(ASIZE);
  localparam logic [CW-1:0] AFULL_C  = AFULL_TH[CW-1:0];
  localparam logic [CW-1:0] AEMPTY_C = AEMPTY_TH[CW-1:0];
  localparam logic [CW-1:0] PTR_ONE  = {{(CW-1){1'b0}}, 1'b1};

  if (!fifo_params_ok(DSIZE, ASIZE, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_param_err
    $fatal(1, "sync_fifo_flags: parameter out of legal range");
  end

  logic [CW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_en_s, rd_en_s;
  logic [DSIZE-1:0] ram_rdata_s;

  // Status decodes straight from the registered pointers.
  assign count         = wptr_q - rptr_q;
  assign rempty        = (wptr_q == rptr_q);
  assign wfull         = (wptr_q[CW-1] != rptr_q[CW-1]) &&
                         (wptr_q[CW-2:0] == rptr_q[CW-2:0]);
  assign walmost_full  = (count >= AFULL_C);
  assign ralmost_empty = (count <= AEMPTY_C);
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

  assign wr_en_s = winc && !wfull;
  assign rd_en_s = rinc && !rempty;

  // Pointer advance and sticky error flags; a same-cycle set beats err_clr.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (wr_en_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_en_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    if (winc && wfull) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (rinc && rempty) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Pointer and error-flag state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= {CW{1'b0}};
      rptr_q <= {CW{1'b0}};
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  sync_fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_en_s),
    .waddr_i(wptr_q[CW-2:0]),
    .wdata_i(wdata),
    .raddr_i(rptr_q[CW-2:0]),
    .rdata_o(ram_rdata_s)
  );

  if (FWFT != 0) begin : g_fwft
    assign rdata = ram_rdata_s;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rd_en_s) begin
        rdata_d = ram_rdata_s;
      end else begin
        rdata_d = rdata_q;
      end
    end

    // Registered read data, held across idle and rejected reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata_q <= {DSIZE{1'b0}};
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and are
// compared against a queue-based occupancy/flag model.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, winc, rinc, err_clr;
  logic [7:0] wdata;

  logic       wfull_a, wafull_a, rempty_a, raempty_a, ovf_a, udf_a;
  logic [7:0] rdata_a;
  logic [3:0] count_a;
  logic       wfull_b, wafull_b, rempty_b, raempty_b, ovf_b, udf_b;
  logic [7:0] rdata_b;
  logic [3:0] count_b;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_a),
    .walmost_full(wafull_a), .rinc(rinc), .rdata(rdata_a), .rempty(rempty_a),
    .ralmost_empty(raempty_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a),
    .err_clr(err_clr)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_b),
    .walmost_full(wafull_b), .rinc(rinc), .rdata(rdata_b), .rempty(rempty_b),
    .ralmost_empty(raempty_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b),
    .err_clr(err_clr)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_udf;
  logic [7:0] m_rdata;

  wire [9:0] stat_a = {count_a, wfull_a, wafull_a, rempty_a, raempty_a, ovf_a, udf_a};
  wire [9:0] stat_b = {count_b, wfull_b, wafull_b, rempty_b, raempty_b, ovf_b, udf_b};

  function automatic logic [9:0] exp_status();
    int n;
    n = q.size();
    return {4'(n), 1'(n == 8), 1'(n >= 6), 1'(n == 0), 1'(n <= 1), m_ovf, m_udf};
  endfunction

  // One clock of stimulus; the model is advanced from the FIFO rules, then outputs settle.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit full, empty;
    winc = w; wdata = d; rinc = r; err_clr = c;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
    end else begin
      full  = (q.size() == 8);
      empty = (q.size() == 0);
      m_ovf = (w && full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = (r && empty) ? 1'b1 : (c ? 1'b0 : m_udf);
      if (r && !empty) m_rdata = q.pop_front();
      if (w && !full) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    vectors++;
    if (stat_a !== 10'b0000_0_0_1_1_0_0) begin
      miscompares++; $display("FAIL reset_status_a got %b exp %b", stat_a, 10'b0000_0_0_1_1_0_0);
    end
    vectors++;
    if (stat_b !== exp_status()) begin
      miscompares++; $display("FAIL reset_status_b got %b exp %b", stat_b, exp_status());
    end
    vectors++;
    if (rdata_a !== 8'h00) begin
      miscompares++; $display("FAIL reset_rdata got %h exp 00", rdata_a);
    end
  endtask

  task automatic test_fill_overflow_drain();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    vectors++;
    if (count_a !== 4'd8 || wfull_a !== 1'b1) begin
      miscompares++; $display("FAIL fill count=%0d wfull=%b exp 8 1", count_a, wfull_a);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    vectors++;
    if (stat_a !== exp_status() || ovf_a !== 1'b1) begin
      miscompares++; $display("FAIL overflow got %b exp %b", stat_a, exp_status());
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rdata_b !== 8'h10 + 8'(i)) begin
        miscompares++; $display("FAIL fwft_head[%0d] got %h exp %h", i, rdata_b, 8'h10 + 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rdata_a !== 8'h10 + 8'(i)) begin
        miscompares++; $display("FAIL drain[%0d] got %h exp %h", i, rdata_a, 8'h10 + 8'(i));
      end
    end
    vectors++;
    if (rempty_a !== 1'b1 || count_a !== 4'd0) begin
      miscompares++; $display("FAIL drained rempty=%b count=%0d exp 1 0", rempty_a, count_a);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (udf_a !== 1'b1 || udf_b !== 1'b1 || rdata_a !== 8'h17) begin
      miscompares++; $display("FAIL underflow udf=%b/%b rdata=%h exp 1/1 17", udf_a, udf_b, rdata_a);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (ovf_a !== 1'b0 || udf_a !== 1'b0 || stat_b !== exp_status()) begin
      miscompares++; $display("FAIL err_clr ovf=%b udf=%b stat_b=%b exp 0 0 %b", ovf_a, udf_a, stat_b, exp_status());
    end
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(8'h40 + 8'(i)), 1'b0, 1'b0);
      if (i >= 5) begin
        vectors++;
        if (wafull_a !== 1'(i >= 6) || stat_a !== exp_status()) begin
          miscompares++; $display("FAIL afull count=%0d got %b exp %b", i, wafull_a, 1'(i >= 6));
        end
      end
    end
    for (int n = 5; n >= 0; n--) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (n <= 2) begin
        vectors++;
        if (raempty_a !== 1'(n <= 1) || stat_a !== exp_status() || rdata_a !== m_rdata) begin
          miscompares++; $display("FAIL aempty count=%0d got %b exp %b rdata %h exp %h", n, raempty_a, 1'(n <= 1), rdata_a, m_rdata);
        end
      end
    end
  endtask

  task automatic test_concurrent_wrap();
    logic [7:0] pat;
    pat = 8'h80;
    for (int i = 0; i < 4; i++) begin step(1'b1, pat, 1'b0, 1'b0); pat++; end
    for (int i = 0; i < 36; i++) begin
      step(1'b1, pat, 1'b1, 1'b0);
      pat++;
      vectors++;
      if (count_a !== 4'd4 || rdata_a !== m_rdata || rdata_a !== 8'(8'h80 + 8'(i))) begin
        miscompares++; $display("FAIL concurrent[%0d] count=%0d rdata=%h exp 4 %h", i, count_a, rdata_a, 8'(8'h80 + 8'(i)));
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_fwft();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    vectors++;
    if (rempty_b !== 1'b0 || rdata_b !== 8'hA5) begin
      miscompares++; $display("FAIL fwft_first rempty=%b rdata=%h exp 0 a5", rempty_b, rdata_b);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (rdata_b !== 8'hA5 || rdata_a !== m_rdata) begin
      miscompares++; $display("FAIL fwft_hold b=%h a=%h exp a5 %h", rdata_b, rdata_a, m_rdata);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (rempty_b !== 1'b1 || rdata_a !== 8'hA5) begin
      miscompares++; $display("FAIL fwft_pop rempty=%b rdata_a=%h exp 1 a5", rempty_b, rdata_a);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    rst_n = 1'b1;
    vectors++;
    if (count_a !== 4'd0 || rempty_a !== 1'b1 || stat_b !== exp_status() || rdata_a !== 8'h00) begin
      miscompares++; $display("FAIL mid_reset count=%0d rempty=%b rdata=%h exp 0 1 00", count_a, rempty_a, rdata_a);
    end
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    vectors++;
    if (rdata_b !== 8'h3C || count_b !== 4'd1) begin
      miscompares++; $display("FAIL post_reset_head got %h count %0d exp 3c 1", rdata_b, count_b);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (rdata_a !== 8'h3C || rempty_a !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_read got %h rempty %b exp 3c 1", rdata_a, rempty_a);
    end
  endtask

  task automatic test_random();
    logic w, r, c;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70));
      c = ($urandom_range(0, 99) < 8);
      step(w, 8'($urandom), r, c);
      vectors++;
      if (stat_a !== exp_status() || stat_b !== exp_status() || rdata_a !== m_rdata) begin
        miscompares++;
        $display("FAIL random[%0d] stat_a=%b stat_b=%b exp %b rdata_a=%h exp %h", i, stat_a, stat_b, exp_status(), rdata_a, m_rdata);
      end
      if (q.size() != 0) begin
        vectors++;
        if (rdata_b !== q[0]) begin
          miscompares++; $display("FAIL random_fwft[%0d] got %h exp %h", i, rdata_b, q[0]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = 8'h00;
    m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
    test_reset();
    test_fill_overflow_drain();
    test_thresholds();
    test_concurrent_wrap();
    test_fwft();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
